// File: rtl/sensor_spi_master_tx_pkg.sv
// sensor_pkt_pkg: shared frame definition for the sensor SPI link.
// Both the transmitting master and the receiving slave import this package.
// Build option: SENSOR_TX_CHECKSUM_EN makes byte 15 a mod-256 sum of
// bytes 0..14; without it byte 15 is sent as 0x00.
package sensor_pkt_pkg;

  localparam int         PKT_BYTES  = 16;
  localparam logic [7:0] PKT_HEADER = 8'hAA;

  // Byte positions inside the frame; byte 0 goes on the wire first.
  localparam int IDX_HEADER = 0;
  localparam int IDX_ID     = 1;
  localparam int IDX_ROLL   = 2;
  localparam int IDX_PITCH  = 4;
  localparam int IDX_YAW    = 6;
  localparam int IDX_GYRO_X = 8;
  localparam int IDX_GYRO_Y = 10;
  localparam int IDX_GYRO_Z = 12;
  localparam int IDX_STATUS = 14;
  localparam int IDX_CSUM   = 15;

  // Angles and rates are two's complement; only their bit patterns travel.
  typedef struct packed {
    logic [7:0]  sensor_id;
    logic [15:0] roll;
    logic [15:0] pitch;
    logic [15:0] yaw;
    logic [15:0] gyro_x;
    logic [15:0] gyro_y;
    logic [15:0] gyro_z;
    logic        error;
    logic        initialized;
  } sensor_pkt_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SCK_LO = 3'd2,
    ST_SCK_HI = 3'd3,
    ST_GAP    = 3'd4,
    ST_HOLD   = 3'd5,
    ST_DONE   = 3'd6
  } tx_state_t;

  // Build the 128-bit frame with byte 0 in the top byte (MSB-first shifting).
  function automatic logic [8*PKT_BYTES-1:0] pack_frame(input sensor_pkt_t p);
    logic [7:0]             b [PKT_BYTES];
    logic [7:0]             csum;
    logic [8*PKT_BYTES-1:0] f;
    b[IDX_HEADER]     = PKT_HEADER;
    b[IDX_ID]         = p.sensor_id;
    b[IDX_ROLL]       = p.roll[15:8];
    b[IDX_ROLL+1]     = p.roll[7:0];
    b[IDX_PITCH]      = p.pitch[15:8];
    b[IDX_PITCH+1]    = p.pitch[7:0];
    b[IDX_YAW]        = p.yaw[15:8];
    b[IDX_YAW+1]      = p.yaw[7:0];
    b[IDX_GYRO_X]     = p.gyro_x[15:8];
    b[IDX_GYRO_X+1]   = p.gyro_x[7:0];
    b[IDX_GYRO_Y]     = p.gyro_y[15:8];
    b[IDX_GYRO_Y+1]   = p.gyro_y[7:0];
    b[IDX_GYRO_Z]     = p.gyro_z[15:8];
    b[IDX_GYRO_Z+1]   = p.gyro_z[7:0];
    b[IDX_STATUS]     = {6'b000000, p.error, p.initialized};
    csum = 8'h00;
`ifdef SENSOR_TX_CHECKSUM_EN
    for (int i = 0; i < PKT_BYTES - 1; i++) begin
      csum = csum + b[i];
    end
`endif
    b[IDX_CSUM] = csum;
    f = {(8*PKT_BYTES){1'b0}};
    for (int i = 0; i < PKT_BYTES; i++) begin
      f[8*(PKT_BYTES-1-i) +: 8] = b[i];
    end
    return f;
  endfunction

endpackage

// File: rtl/sensor_spi_master_tx_sck_timer.sv
// spi_sck_timer: down-counter that times one FSM phase.
// Loading N-1 on state entry makes o_phase_done rise in the N-th cycle of
// that state, so a load value of 0 gives a one-cycle phase.
module spi_sck_timer #(
  parameter int W = 7
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_phase_done
);

  logic [W-1:0] r_cnt;

  // Reload on state change, otherwise count down and park at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= W'(0);
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != W'(0)) begin
      r_cnt <= r_cnt - W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_phase_done = (r_cnt == W'(0));

endmodule

// File: rtl/sensor_spi_master_tx.sv
// sensor_spi_master_tx: sends one 16-byte sensor packet as an SPI mode-0,
// MSB-first frame with active-low chip select. Fields are captured on the
// valid/ready handshake and then shifted out without further input.
// Build option: SENSOR_TX_CHECKSUM_EN selects the checksum byte content
// (handled in sensor_pkt_pkg::pack_frame); timing is the same either way.
module sensor_spi_master_tx
  import sensor_pkt_pkg::*;
#(
  parameter int CLK_DIV  = 120,
  parameter int CS_SETUP = 24,
  parameter int BYTE_GAP = 0,
  parameter int CS_HOLD  = 24
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pkt_valid,
  output logic               o_pkt_ready,
  input  logic [7:0]         i_sensor_id,
  input  logic signed [15:0] i_roll,
  input  logic signed [15:0] i_pitch,
  input  logic signed [15:0] i_yaw,
  input  logic signed [15:0] i_gyro_x,
  input  logic signed [15:0] i_gyro_y,
  input  logic signed [15:0] i_gyro_z,
  input  logic               i_initialized,
  input  logic               i_error,
  output logic               o_spi_sck,
  output logic               o_spi_sdo,
  output logic               o_spi_cs_n,
  output logic               o_busy,
  output logic               o_done
);

  localparam int MAX_A  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B  = (CS_HOLD > BYTE_GAP) ? CS_HOLD : BYTE_GAP;
  localparam int MAX_PH = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int PH_W   = $clog2(MAX_PH + 1);

  localparam logic [PH_W-1:0] LD_SETUP = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0] LD_DIV   = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] LD_HOLD  = PH_W'(CS_HOLD - 1);
  localparam logic [PH_W-1:0] LD_GAP   = PH_W'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);

  tx_state_t        r_state;
  tx_state_t        w_state_next;
  logic [127:0]     r_shift;
  logic [6:0]       r_bit_cnt;
  sensor_pkt_t      w_fields;
  logic [127:0]     w_frame;
  logic             w_accept;
  logic             w_shift_en;
  logic             w_active_next;
  logic             w_load;
  logic [PH_W-1:0]  w_load_val;
  logic             w_phase_done;

  assign w_fields = '{sensor_id:   i_sensor_id,
                      roll:        i_roll,
                      pitch:       i_pitch,
                      yaw:         i_yaw,
                      gyro_x:      i_gyro_x,
                      gyro_y:      i_gyro_y,
                      gyro_z:      i_gyro_z,
                      error:       i_error,
                      initialized: i_initialized};
  assign w_frame   = pack_frame(w_fields);
  assign o_spi_sdo = r_shift[127];

  spi_sck_timer #(.W(PH_W)) u_timer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load       (w_load),
    .i_load_val   (w_load_val),
    .o_phase_done (w_phase_done)
  );

  // Next-state logic; a shift (new bit on sdo) only happens when SCK falls into SCK_LO.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_shift_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_pkt_valid) begin
          w_state_next = ST_SETUP;
          w_accept     = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (w_phase_done) w_state_next = ST_SCK_LO;
        else              w_state_next = ST_SETUP;
      end
      ST_SCK_LO: begin
        if (w_phase_done) w_state_next = ST_SCK_HI;
        else              w_state_next = ST_SCK_LO;
      end
      ST_SCK_HI: begin
        if (!w_phase_done) begin
          w_state_next = ST_SCK_HI;
        end else if (r_bit_cnt == 7'd127) begin
          w_state_next = ST_HOLD;
        end else if ((r_bit_cnt[2:0] == 3'd7) && (BYTE_GAP > 0)) begin
          w_state_next = ST_GAP;
        end else begin
          w_state_next = ST_SCK_LO;
          w_shift_en   = 1'b1;
        end
      end
      ST_GAP: begin
        if (w_phase_done) begin
          w_state_next = ST_SCK_LO;
          w_shift_en   = 1'b1;
        end else begin
          w_state_next = ST_GAP;
        end
      end
      ST_HOLD: begin
        if (w_phase_done) w_state_next = ST_DONE;
        else              w_state_next = ST_HOLD;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    w_active_next = (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);
  end

  // Phase length for the state being entered; the timer reloads on every state change.
  always_comb begin
    w_load = (w_state_next != r_state);
    case (w_state_next)
      ST_SETUP:  w_load_val = LD_SETUP;
      ST_SCK_LO: w_load_val = LD_DIV;
      ST_SCK_HI: w_load_val = LD_DIV;
      ST_GAP:    w_load_val = LD_GAP;
      ST_HOLD:   w_load_val = LD_HOLD;
      default:   w_load_val = PH_W'(0);
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Frame shift register and bit counter; cleared at frame end so sdo idles low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift   <= 128'd0;
      r_bit_cnt <= 7'd0;
    end else if (w_accept) begin
      r_shift   <= w_frame;
      r_bit_cnt <= 7'd0;
    end else if (w_shift_en) begin
      r_shift   <= {r_shift[126:0], 1'b0};
      r_bit_cnt <= r_bit_cnt + 7'd1;
    end else if (w_state_next == ST_DONE) begin
      r_shift   <= 128'd0;
      r_bit_cnt <= r_bit_cnt;
    end else begin
      r_shift   <= r_shift;
      r_bit_cnt <= r_bit_cnt;
    end
  end

  // Registered bus/handshake outputs decoded from the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_spi_cs_n  <= 1'b1;
      o_spi_sck   <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pkt_ready <= 1'b1;
    end else begin
      o_spi_cs_n  <= !w_active_next;
      o_spi_sck   <= (w_state_next == ST_SCK_HI);
      o_busy      <= w_active_next;
      o_done      <= (w_state_next == ST_DONE);
      o_pkt_ready <= (w_state_next == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_sensor_spi_master_tx.sv
// Bench for sensor_spi_master_tx: two instances (no byte gap / byte gap 3)
// share clock, reset and packet inputs. A bus-model slave per instance
// decodes frames on SCK rising edges and compares against a byte-level
// reference model of the frame layout.
module tb_sensor_spi_master_tx;

  localparam int A_DIV = 2, A_SETUP = 2, A_GAP = 0, A_HOLD = 2;
  localparam int B_DIV = 1, B_SETUP = 3, B_GAP = 3, B_HOLD = 1;
  localparam int A_LEN = A_SETUP + 256*A_DIV + 15*A_GAP + A_HOLD;
  localparam int B_LEN = B_SETUP + 256*B_DIV + 15*B_GAP + B_HOLD;
`ifdef SENSOR_TX_CHECKSUM_EN
  localparam logic [127:0] VEC_FRAME = 128'hAA01_1234_FFFE_0000_0102_8000_7FFF_03F2;
`else
  localparam logic [127:0] VEC_FRAME = 128'hAA01_1234_FFFE_0000_0102_8000_7FFF_0300;
`endif

  logic        clk, rst, valid;
  logic [7:0]  f_id;
  logic [15:0] f_roll, f_pitch, f_yaw, f_gx, f_gy, f_gz;
  logic        f_init, f_err;
  logic [1:0]  ready, sck, sdo, csn, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  sensor_spi_master_tx #(.CLK_DIV(A_DIV), .CS_SETUP(A_SETUP), .BYTE_GAP(A_GAP), .CS_HOLD(A_HOLD)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_pkt_valid(valid), .o_pkt_ready(ready[0]),
    .i_sensor_id(f_id), .i_roll(f_roll), .i_pitch(f_pitch), .i_yaw(f_yaw),
    .i_gyro_x(f_gx), .i_gyro_y(f_gy), .i_gyro_z(f_gz),
    .i_initialized(f_init), .i_error(f_err),
    .o_spi_sck(sck[0]), .o_spi_sdo(sdo[0]), .o_spi_cs_n(csn[0]), .o_busy(busy[0]), .o_done(done[0]));

  sensor_spi_master_tx #(.CLK_DIV(B_DIV), .CS_SETUP(B_SETUP), .BYTE_GAP(B_GAP), .CS_HOLD(B_HOLD)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_pkt_valid(valid), .o_pkt_ready(ready[1]),
    .i_sensor_id(f_id), .i_roll(f_roll), .i_pitch(f_pitch), .i_yaw(f_yaw),
    .i_gyro_x(f_gx), .i_gyro_y(f_gy), .i_gyro_z(f_gz),
    .i_initialized(f_init), .i_error(f_err),
    .o_spi_sck(sck[1]), .o_spi_sdo(sdo[1]), .o_spi_cs_n(csn[1]), .o_busy(busy[1]), .o_done(done[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: frame bytes computed from the field rules.
  function automatic logic [127:0] ref_frame(input logic [7:0] id, input logic [15:0] r, p, y, gx, gy, gz,
                                             input logic ini, input logic err);
    int b[16];
    int sum;
    logic [127:0] f;
    b[0] = 170; b[1] = int'(id);
    b[2] = int'(r) / 256;  b[3] = int'(r) % 256;
    b[4] = int'(p) / 256;  b[5] = int'(p) % 256;
    b[6] = int'(y) / 256;  b[7] = int'(y) % 256;
    b[8] = int'(gx) / 256; b[9] = int'(gx) % 256;
    b[10] = int'(gy) / 256; b[11] = int'(gy) % 256;
    b[12] = int'(gz) / 256; b[13] = int'(gz) % 256;
    b[14] = 2*int'(err) + int'(ini);
    sum = 0;
    for (int i = 0; i < 15; i++) sum += b[i];
`ifdef SENSOR_TX_CHECKSUM_EN
    b[15] = sum % 256;
`else
    b[15] = 0;
`endif
    f = 128'd0;
    for (int i = 0; i < 16; i++) f = (f << 8) | 128'(b[i]);
    return f;
  endfunction

  // Scoreboard and bus-model state, index 0 = dut_a, 1 = dut_b.
  logic [127:0] exp_frame [2][64];
  int           exp_wr[2], exp_rd[2], flushed[2];
  int           exp_len[2];
  logic [127:0] got[2], last_frame[2];
  int           nbits[2], low_len[2], high_len[2], frames_ok[2];
  int           viol_mode0[2], viol_busy[2], viol_ready[2], viol_stray[2];
  int           min_gap[2], max_gap[2];
  logic [1:0]   prev_sck, prev_sdo, prev_csn;
  logic         mon_en, track_gap;

  // Bus-model slave: samples away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        if (!csn[d]) begin
          if (prev_csn[d]) begin
            if (track_gap) begin
              if (high_len[d] < min_gap[d]) min_gap[d] = high_len[d];
              if (high_len[d] > max_gap[d]) max_gap[d] = high_len[d];
            end
            low_len[d] = 0;
            nbits[d] = 0;
          end
          low_len[d]++;
          if (sck[d] && !prev_sck[d]) begin
            if (nbits[d] < 128) got[d] = {got[d][126:0], sdo[d]};
            nbits[d]++;
          end
          if (sck[d] && prev_sck[d] && (sdo[d] != prev_sdo[d])) viol_mode0[d]++;
          if (done[d]) viol_stray[d]++;
        end else begin
          if (sck[d]) viol_mode0[d]++;
          if (!prev_csn[d]) begin
            high_len[d] = 1;
            if (nbits[d] == 128) begin
              last_frame[d] = got[d];
              if (exp_rd[d] < exp_wr[d]) begin
                check($sformatf("frame%0d", d), got[d], exp_frame[d][exp_rd[d] % 64]);
                exp_rd[d]++;
              end else begin
                check($sformatf("unexpected_frame%0d", d), 128'(exp_rd[d]), 128'(exp_wr[d] + 1));
              end
              check($sformatf("cs_low_len%0d", d), 128'(low_len[d]), 128'(exp_len[d]));
              check($sformatf("done_pulse%0d", d), 128'(done[d]), 128'(1));
              frames_ok[d]++;
            end else if (done[d]) begin
              viol_stray[d]++;
            end
            nbits[d] = 0;
          end else begin
            high_len[d]++;
            if (done[d]) viol_stray[d]++;
          end
        end
        if (busy[d] == csn[d]) viol_busy[d]++;
        if (busy[d] && ready[d]) viol_ready[d]++;
      end
      prev_sck = sck;
      prev_sdo = sdo;
      prev_csn = csn;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_fields();
    f_id = 8'($urandom);
    f_roll = 16'($urandom); f_pitch = 16'($urandom); f_yaw = 16'($urandom);
    f_gx = 16'($urandom);   f_gy = 16'($urandom);    f_gz = 16'($urandom);
    f_init = 1'($urandom);  f_err = 1'($urandom);
  endtask

  // Records an expected frame for each instance that will accept at the coming edge.
  task automatic note_accept();
    for (int d = 0; d < 2; d++) begin
      if (valid && ready[d] && !rst) begin
        exp_frame[d][exp_wr[d] % 64] = ref_frame(f_id, f_roll, f_pitch, f_yaw, f_gx, f_gy, f_gz, f_init, f_err);
        exp_wr[d]++;
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      tick();
      valid = 1'b0;
      randomize_fields();
      if (exp_rd[0] == exp_wr[0] && exp_rd[1] == exp_wr[1] && ready == 2'b11) ok = 1'b1;
    end
    check(tag, 128'(ok), 128'(1));
  endtask

  // One-cycle valid pulse with the fields currently set up, then scramble inputs.
  task automatic pulse_valid();
    valid = 1'b1;
    note_accept();
    tick();
    valid = 1'b0;
    randomize_fields();
  endtask

  initial begin
    int start;
    rst = 1'b1; valid = 1'b0; mon_en = 1'b0; track_gap = 1'b0;
    randomize_fields();
    exp_len[0] = A_LEN; exp_len[1] = B_LEN;
    for (int d = 0; d < 2; d++) begin
      exp_wr[d] = 0; exp_rd[d] = 0; flushed[d] = 0; nbits[d] = 0; low_len[d] = 0; high_len[d] = 0;
      frames_ok[d] = 0; viol_mode0[d] = 0; viol_busy[d] = 0; viol_ready[d] = 0; viol_stray[d] = 0;
      min_gap[d] = 1000; max_gap[d] = 0; got[d] = 128'd0; last_frame[d] = 128'd0;
    end
    prev_sck = 2'b00; prev_sdo = 2'b00; prev_csn = 2'b11;
    repeat (3) tick();
    check("rst_ready", 128'(ready), 128'(2'b11));
    check("rst_cs_n",  128'(csn),   128'(2'b11));
    check("rst_sck",   128'(sck),   128'(2'b00));
    check("rst_sdo",   128'(sdo),   128'(2'b00));
    check("rst_busy",  128'(busy),  128'(2'b00));
    check("rst_done",  128'(done),  128'(2'b00));
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Directed vector from the frame-layout example.
    f_id = 8'h01; f_roll = 16'h1234; f_pitch = 16'hFFFE; f_yaw = 16'h0000;
    f_gx = 16'h0102; f_gy = 16'h8000; f_gz = 16'h7FFF; f_init = 1'b1; f_err = 1'b1;
    pulse_valid();
    check("t1_cs_n",  128'(csn),   128'(2'b00));
    check("t1_busy",  128'(busy),  128'(2'b11));
    check("t1_ready", 128'(ready), 128'(2'b00));
    check("t1_sdo",   128'(sdo),   128'(2'b11));
    wait_drain("drain_vector");
    check("vector_a", last_frame[0], VEC_FRAME);
    check("vector_b", last_frame[1], VEC_FRAME);

    // Random packets with random idle time, inputs scrambled after acceptance.
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 7)) begin
        tick();
        randomize_fields();
      end
      tick();
      randomize_fields();
      pulse_valid();
      wait_drain($sformatf("drain_rand%0d", k));
    end

    // Valid held high with fields changing every cycle.
    start = exp_wr[0];
    for (int i = 0; i < 4000; i++) begin
      tick();
      randomize_fields();
      valid = 1'b1;
      note_accept();
      if (i == 5) begin
        for (int d = 0; d < 2; d++) begin min_gap[d] = 1000; max_gap[d] = 0; end
        track_gap = 1'b1;
      end
      if (exp_wr[0] >= start + 5) break;
    end
    tick();
    valid = 1'b0;
    wait_drain("drain_load");
    track_gap = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("gap_min%0d", d), 128'(min_gap[d]), 128'(2));
      check($sformatf("gap_max%0d", d), 128'(max_gap[d]), 128'(2));
    end

    // Reset during byte 7 of dut_a's frame.
    tick();
    randomize_fields();
    pulse_valid();
    repeat (A_SETUP + 7*8*2*A_DIV + 8) tick();
    rst = 1'b1;
    tick();
    check("mrst_cs_n",  128'(csn),   128'(2'b11));
    check("mrst_sck",   128'(sck),   128'(2'b00));
    check("mrst_busy",  128'(busy),  128'(2'b00));
    check("mrst_done",  128'(done),  128'(2'b00));
    check("mrst_ready", 128'(ready), 128'(2'b11));
    for (int d = 0; d < 2; d++) begin
      flushed[d] += exp_wr[d] - exp_rd[d];
      exp_rd[d] = exp_wr[d];
    end
    rst = 1'b0;
    repeat (3) tick();
    randomize_fields();
    pulse_valid();
    wait_drain("drain_after_rst");

    for (int d = 0; d < 2; d++) begin
      check($sformatf("mode0_viol%0d", d), 128'(viol_mode0[d]), 128'(0));
      check($sformatf("busy_viol%0d", d),  128'(viol_busy[d]),  128'(0));
      check($sformatf("ready_viol%0d", d), 128'(viol_ready[d]), 128'(0));
      check($sformatf("stray_done%0d", d), 128'(viol_stray[d]), 128'(0));
      check($sformatf("frame_count%0d", d), 128'(frames_ok[d]), 128'(exp_wr[d] - flushed[d]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sensor_spi_master_tx.md
Name: sensor_spi_master_tx

Overview:
- SPI master that serializes one 16-byte sensor packet onto an SPI bus (mode 0, MSB first, active-low CS).
- Produces the exact frame the FPGA's sensor-receive SPI slave expects.
- Used as an on-FPGA loopback/self-test source, and to forward sensor frames to a downstream FPGA.
- Fields are latched on a valid/ready handshake, then shifted out autonomously.

Parameters:
- CLK_DIV, 120: clk cycles per SCK half-period. 100 kHz SCK at 24 MHz clk. Legal range is 1 or more.
- CS_SETUP, 24: clk cycles from cs_n falling to the first SCK rising edge. Legal range is 1 or more.
- BYTE_GAP, 0: extra clk cycles, SCK held low, between bytes.
- CS_HOLD, 24: clk cycles from the last SCK falling edge to cs_n rising. Legal range is 1 or more.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- pkt_valid  in  1  packet fields are valid
- pkt_ready  out  1  high when IDLE; transfer accepted on pkt_valid && pkt_ready at a clk edge
- sensor_id  in  8  packet byte 1
- roll, pitch, yaw  in  16 each  signed Euler angles
- gyro_x, gyro_y, gyro_z  in  16 each  signed gyro rates
- initialized  in  1  goes to status bit 0
- error  in  1  goes to status bit 1
- spi_sck  out  1  SPI clock, idles low
- spi_sdo  out  1  MOSI
- spi_cs_n  out  1  chip select, active low
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle pulse when a frame completes

Behaviour:
- Frame layout, transmitted in this order:
  - Byte 0: 0xAA
  - Byte 1: sensor_id
  - Bytes 2-13: roll, pitch, yaw, gyro_x, gyro_y, gyro_z, each MSB byte first
  - Byte 14: {6'b0, error, initialized}
  - Byte 15: checksum (see Optional Feature)
- Reset values: spi_cs_n=1, spi_sck=0, spi_sdo=0, busy=0, done=0, pkt_ready=1, state=IDLE.
- Acceptance: at handshake edge T, all fields are latched into a 128-bit shift register. Input changes afterwards have no effect.
- States and transitions:
  - IDLE → SETUP on handshake.
  - SETUP (CS_SETUP cycles) → SCK_LO.
  - SCK_LO (CLK_DIV cycles) → SCK_HI.
  - SCK_HI (CLK_DIV cycles) → SCK_LO (next bit); GAP (byte done, BYTE_GAP>0); or HOLD (bit 127).
  - GAP → SCK_LO.
  - HOLD (CS_HOLD cycles) → DONE.
  - DONE (1 cycle) → IDLE.
- Timing after handshake:
  - In cycle T+1: spi_cs_n=0, busy=1, pkt_ready=0, spi_sdo = bit 127 (byte 0 bit 7).
- Bit timing:
  - spi_sdo changes only on SCK falling transitions, i.e. entering SCK_LO from SCK_HI/GAP. It is stable for the whole high phase.
  - The slave samples on the SCK rising edge.
- Frame duration: from the first cs_n-low cycle to the last cs_n-low cycle inclusive, CS_SETUP + 256*CLK_DIV + 15*BYTE_GAP + CS_HOLD cycles.
- DONE cycle: spi_cs_n=1, done=1, busy=0.
- Back-to-back frames: pkt_ready returns to 1 the cycle after DONE. Minimum cs_n-high time between frames is 2 cycles.
- pkt_valid while busy is ignored; no queuing.
- rst mid-frame: takes effect at the next edge. All outputs go to reset values; no done pulse. The partial frame is discarded by the slave when CS rises.
- Counters:
  - Bit counter: 7 bits, 0..127, no wrap past 127.
  - Phase counter: width $clog2(max(CLK_DIV, CS_SETUP, CS_HOLD, BYTE_GAP)+1).

Optional Feature:
- Macro: SENSOR_TX_CHECKSUM_EN.
- Defined: byte 15 = (sum of bytes 0..14) mod 256, computed combinationally from the latched fields.
- Undefined: byte 15 = 0x00.
- All timing is identical in both builds.

Decomposition:
- Package sensor_pkt_pkg, containing:
  - PKT_BYTES=16
  - PKT_HEADER=8'hAA
  - byte-index localparams
  - a sensor_pkt_t packed struct for the fields
  - a pack function that builds the 128-bit frame
- The receiving slave imports the same package.
- One sub-module, spi_sck_timer: phase counter that issues phase_done. Instantiated once and reloaded per state.

Test Plan:
- Frame contents, checksum build (CLK_DIV=2, CS_SETUP=2, CS_HOLD=2, BYTE_GAP=0):
  - Stimulus: id=0x01, roll=0x1234, pitch=0xFFFE, yaw=0x0000, gx=0x0102, gy=0x8000, gz=0x7FFF, init=1, err=1.
  - Required: bus-model slave decodes AA 01 12 34 FF FE 00 00 01 02 80 00 7F FF 03 F2.
  - Required: cs_n low exactly 516 cycles; single done pulse.
- Same stimulus without SENSOR_TX_CHECKSUM_EN: byte 15 = 0x00; all other bytes and timing unchanged.
- Mode-0 timing: assert spi_sdo never changes while spi_sck=1. Assert spi_sck=0 whenever spi_cs_n=1.
- Handshake under load:
  - Hold pkt_valid high continuously with changing fields.
  - Frames must carry only the values present at each accept edge.
  - pkt_ready low throughout busy; cs_n-high gap of 2 cycles between frames.
- Reset mid-frame: assert rst during byte 7. Next cycle cs_n=1, sck=0, busy=0, no done pulse. A new packet then transmits correctly.
- BYTE_GAP=3: sck stays low 3 extra cycles after each of bytes 0-14. Total cs_n-low = CS_SETUP + 256*CLK_DIV + 45 + CS_HOLD.
